// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - single-bit stability counter with registered level and edge pulses
module debounce_bit #(
  parameter int   CNT_WIDTH     = 16,
  parameter int   STABLE_CYCLES = 50000,
  parameter logic INIT_BIT      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic pulse_next
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 q_next;
  logic                 rise_next;
  logic                 fall_next;

  // Any sample equal to q clears the count, so a bounce restarts the window.
  always_comb begin
    cnt_next  = '0;
    q_next    = q;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (d != q) begin
      if (cnt == LAST) begin
        q_next    = d;
        rise_next = d;
        fall_next = ~d;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  assign pulse_next = rise_next | fall_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= INIT_BIT;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      q    <= q_next;
      cnt  <= cnt_next;
      rise <= rise_next;
      fall <= fall_next;
    end
  end

endmodule

// File: rtl/debouncer.sv
// rtl/debouncer.sv - per-bit debounce and edge detect for synchronized inputs
module debouncer #(
  parameter int   WIDTH         = 1,
  parameter int   CNT_WIDTH     = 16,
  parameter int   STABLE_CYCLES = 50000,
  parameter logic INIT          = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] pulse_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .CNT_WIDTH    (CNT_WIDTH),
      .STABLE_CYCLES(STABLE_CYCLES),
      .INIT_BIT     (INIT)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .d         (d[i]),
      .q         (q[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .pulse_next(pulse_next[i])
    );
  end

  // Registered from next-state pulses so it lines up with rise/fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      changed <= 1'b0;
    end else begin
      changed <= |pulse_next;
    end
  end

endmodule
